// File: rtl/frac_clken_pkg.sv
// Shared types and helpers for the fractional clock-enable generator.
package frac_clken_pkg;

    // Default channel count and matching channel-select width.
    localparam int unsigned NUM_CH_DEF = 2;
    localparam int unsigned CH_W       = (NUM_CH_DEF > 1) ? $clog2(NUM_CH_DEF) : 1;

    // Config travels zero-extended to this width, so ACC_W may be at most CFG_W.
    localparam int unsigned CFG_W = 32;

    typedef struct packed {
        logic [CFG_W-1:0] inc;
        logic [CFG_W-1:0] mod;
    } chan_cfg_t;

    // A ratio is usable only if it produces at most one enable per cycle.
    function automatic logic cfg_valid(input logic [CFG_W-1:0] inc, input logic [CFG_W-1:0] mod);
        return (mod != '0) && (inc <= mod);
    endfunction

    // Width of a channel-select field for n channels (never zero).
    function automatic int unsigned ch_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/frac_clken_chan.sv
// One fractional-rate enable channel: config, phase accumulator, ce pulse and toggle.
module frac_clken_chan
    import frac_clken_pkg::*;
#(
    parameter int unsigned ACC_W   = 16,
    parameter int unsigned DEF_INC = 12,
    parameter int unsigned DEF_MOD = 25
) (
    input  logic      refclk,
    input  logic      rst_n,
    input  logic      i_wr,
    input  chan_cfg_t i_cfg,
    output logic      o_ce,
    output logic      o_tgl,
    output logic      o_valid
);

    localparam int unsigned SUM_W = CFG_W + 1;
    localparam chan_cfg_t   RST_CFG = '{
        inc: CFG_W'(ACC_W'(DEF_INC)),
        mod: CFG_W'(ACC_W'(DEF_MOD))
    };

    chan_cfg_t        r_cfg;
    logic [ACC_W-1:0] r_acc;
    logic             r_ce;
    logic             r_tgl;

    logic [SUM_W-1:0] w_sum;
    logic             w_cross;
    logic             w_valid;
    logic [ACC_W-1:0] w_acc_nxt;

    // Accumulator step; acc < mod and inc <= mod keep the remainder below mod.
    always_comb begin
        w_sum     = SUM_W'(r_acc) + SUM_W'(r_cfg.inc);
        w_cross   = (w_sum >= SUM_W'(r_cfg.mod));
        w_valid   = cfg_valid(r_cfg.inc, r_cfg.mod);
        w_acc_nxt = w_cross ? ACC_W'(w_sum - SUM_W'(r_cfg.mod)) : ACC_W'(w_sum);
    end

    // Config load, phase advance and registered ce/toggle; a write beats a crossing.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            r_cfg <= RST_CFG;
            r_acc <= '0;
            r_ce  <= 1'b0;
            r_tgl <= 1'b0;
        end else if (i_wr) begin
            r_cfg <= i_cfg;
            r_acc <= '0;
            r_ce  <= 1'b0;
        end else if (!w_valid) begin
            r_acc <= '0;
            r_ce  <= 1'b0;
        end else begin
            r_acc <= w_acc_nxt;
            r_ce  <= w_cross;
            if (w_cross) begin
                r_tgl <= ~r_tgl;
            end
        end
    end

    assign o_ce    = r_ce;
    assign o_tgl   = r_tgl;
    assign o_valid = w_valid;

endmodule

// File: rtl/frac_clken_gen.sv
// Multi-channel fractional clock-enable generator with write decode, lock tracking
// and a sticky invalid-config flag.
module frac_clken_gen
    import frac_clken_pkg::*;
#(
    parameter int unsigned NUM_CH      = 2,
    parameter int unsigned ACC_W       = 16,
    parameter int unsigned LOCK_CYCLES = 16,
    parameter int unsigned DEF_INC     = 12,
    parameter int unsigned DEF_MOD     = 25
) (
    input  logic                        refclk,
    input  logic                        rst_n,
    input  logic                        cfg_we,
    input  logic [ch_width(NUM_CH)-1:0] cfg_ch,
    input  logic [ACC_W-1:0]            cfg_inc,
    input  logic [ACC_W-1:0]            cfg_mod,
    output logic [NUM_CH-1:0]           ce,
    output logic [NUM_CH-1:0]           clk_tgl,
    output logic                        locked,
    output logic                        cfg_err
);

    localparam int unsigned LCK_W = $clog2(LOCK_CYCLES + 1);

    logic [LCK_W-1:0]  r_lock_cnt;
    logic              r_cfg_err;

    chan_cfg_t         w_wr_cfg;
    logic              w_in_range;
    logic              w_accept;
    logic              w_wr_ok;
    logic [NUM_CH-1:0] w_wr;
    logic [NUM_CH-1:0] w_valid;

    // Decode the write; out-of-range channel numbers are dropped entirely.
    always_comb begin
        w_wr_cfg   = '{inc: CFG_W'(cfg_inc), mod: CFG_W'(cfg_mod)};
        w_in_range = (32'(cfg_ch) < NUM_CH);
        w_accept   = cfg_we && w_in_range;
        w_wr_ok    = cfg_valid(w_wr_cfg.inc, w_wr_cfg.mod);
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
        assign w_wr[g] = w_accept && (32'(cfg_ch) == 32'(g));

        frac_clken_chan #(
            .ACC_W   (ACC_W),
            .DEF_INC (DEF_INC),
            .DEF_MOD (DEF_MOD)
        ) u_chan (
            .refclk  (refclk),
            .rst_n   (rst_n),
            .i_wr    (w_wr[g]),
            .i_cfg   (w_wr_cfg),
            .o_ce    (ce[g]),
            .o_tgl   (clk_tgl[g]),
            .o_valid (w_valid[g])
        );
    end

    // Lock counter: restarts on every accepted write, saturates at LOCK_CYCLES.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            r_lock_cnt <= '0;
        end else if (w_accept) begin
            r_lock_cnt <= '0;
        end else if (r_lock_cnt != LCK_W'(LOCK_CYCLES)) begin
            r_lock_cnt <= r_lock_cnt + 1'b1;
        end
    end

    // Sticky error: any accepted write carrying an unusable ratio.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            r_cfg_err <= 1'b0;
        end else if (w_accept && !w_wr_ok) begin
            r_cfg_err <= 1'b1;
        end
    end

    assign locked  = (r_lock_cnt == LCK_W'(LOCK_CYCLES)) && (&w_valid);
    assign cfg_err = r_cfg_err;

endmodule

// File: tb/tb_frac_clken_gen.sv
// Self-checking bench for frac_clken_gen: directed vector table, hand-written
// corner sequences and randomized writes against a ratio-based reference model.
module tb_frac_clken_gen;

    localparam int NCH  = 3;
    localparam int LOCK = 16;

    logic           refclk = 1'b0;
    logic           rst_n  = 1'b0;
    logic           cfg_we = 1'b0;
    logic [1:0]     cfg_ch = '0;
    logic [15:0]    cfg_inc = '0;
    logic [15:0]    cfg_mod = '0;
    logic [NCH-1:0] ce;
    logic [NCH-1:0] clk_tgl;
    logic           locked;
    logic           cfg_err;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state: ratio per channel and edges since its phase restart.
    longint         m_inc [NCH];
    longint         m_mod [NCH];
    longint         m_k   [NCH];
    logic [NCH-1:0] m_ce;
    logic [NCH-1:0] m_tgl;
    int             m_lk;
    logic           m_err;
    logic           m_locked;

    typedef struct {
        int ch;
        int inc;
        int mod;
        int n;
        int exp_ce;
        int exp_lock_at;
        bit exp_err;
    } vec_t;

    vec_t vecs [7];

    int   cnt;
    int   lock_at;
    bit   prev;
    bit   dbl;
    logic [2:0] seq;
    int   r_ch;
    int   r_inc;
    int   r_mod;

    frac_clken_gen #(
        .NUM_CH      (NCH),
        .ACC_W       (16),
        .LOCK_CYCLES (LOCK),
        .DEF_INC     (12),
        .DEF_MOD     (25)
    ) dut (
        .refclk  (refclk),
        .rst_n   (rst_n),
        .cfg_we  (cfg_we),
        .cfg_ch  (cfg_ch),
        .cfg_inc (cfg_inc),
        .cfg_mod (cfg_mod),
        .ce      (ce),
        .clk_tgl (clk_tgl),
        .locked  (locked),
        .cfg_err (cfg_err)
    );

    always #5 refclk = ~refclk;

    function automatic bit ratio_ok(input longint inc, input longint mod);
        return (mod != 0) && (inc <= mod);
    endfunction

    // Enable after k edges of phase: the count floor(k*inc/mod) just went up.
    function automatic bit ce_at(input longint k, input longint inc, input longint mod);
        if (!ratio_ok(inc, mod) || k == 0) return 1'b0;
        return ((k * inc) / mod) != (((k - 1) * inc) / mod);
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_inc[c] = 12;
            m_mod[c] = 25;
            m_k[c]   = 0;
        end
        m_ce     = '0;
        m_tgl    = '0;
        m_lk     = 0;
        m_err    = 1'b0;
        m_locked = 1'b0;
    endtask

    task automatic model_step();
        bit acc_wr;
        bit all_ok;
        acc_wr = cfg_we && (int'(cfg_ch) < NCH);
        all_ok = 1'b1;
        for (int c = 0; c < NCH; c++) begin
            if (acc_wr && int'(cfg_ch) == c) begin
                m_inc[c] = longint'(cfg_inc);
                m_mod[c] = longint'(cfg_mod);
                m_k[c]   = 0;
            end else begin
                m_k[c]++;
            end
            m_ce[c] = ce_at(m_k[c], m_inc[c], m_mod[c]);
            if (m_ce[c]) m_tgl[c] = ~m_tgl[c];
            if (!ratio_ok(m_inc[c], m_mod[c])) all_ok = 1'b0;
        end
        if (acc_wr) begin
            m_lk = 0;
            if (!ratio_ok(longint'(cfg_inc), longint'(cfg_mod))) m_err = 1'b1;
        end else if (m_lk < LOCK) begin
            m_lk++;
        end
        m_locked = (m_lk == LOCK) && all_ok;
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    endtask

    task automatic tick();
        @(posedge refclk);
        model_step();
        #1;
        chk("cycle_outputs", 64'({ce, clk_tgl, locked, cfg_err}),
            64'({m_ce, m_tgl, m_locked, m_err}));
    endtask

    task automatic write(input int ch, input int inc, input int mod);
        cfg_we  = 1'b1;
        cfg_ch  = 2'(ch);
        cfg_inc = 16'(inc);
        cfg_mod = 16'(mod);
        tick();
        cfg_we  = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        chk("reset_outputs", 64'({ce, clk_tgl, locked, cfg_err}), 64'(0));
        model_reset();
        @(negedge refclk);
        rst_n = 1'b1;
    endtask

    task automatic run_count(input int ch, input int n);
        cnt     = 0;
        lock_at = 0;
        prev    = 1'b0;
        dbl     = 1'b0;
        for (int t = 1; t <= n; t++) begin
            tick();
            if (ce[ch]) cnt++;
            if (ce[ch] && prev) dbl = 1'b1;
            prev = ce[ch];
            if (locked && lock_at == 0) lock_at = t;
        end
    endtask

    initial begin
        vecs[0] = '{ch: 1, inc: 5,  mod: 5,  n: 20, exp_ce: 20, exp_lock_at: 16, exp_err: 1'b0};
        vecs[1] = '{ch: 0, inc: 1,  mod: 4,  n: 40, exp_ce: 10, exp_lock_at: 16, exp_err: 1'b0};
        vecs[2] = '{ch: 2, inc: 12, mod: 25, n: 50, exp_ce: 24, exp_lock_at: 16, exp_err: 1'b0};
        vecs[3] = '{ch: 1, inc: 3,  mod: 7,  n: 70, exp_ce: 30, exp_lock_at: 16, exp_err: 1'b0};
        vecs[4] = '{ch: 2, inc: 0,  mod: 9,  n: 20, exp_ce: 0,  exp_lock_at: 16, exp_err: 1'b0};
        vecs[5] = '{ch: 0, inc: 7,  mod: 3,  n: 30, exp_ce: 0,  exp_lock_at: 0,  exp_err: 1'b1};
        vecs[6] = '{ch: 0, inc: 1,  mod: 4,  n: 40, exp_ce: 10, exp_lock_at: 16, exp_err: 1'b1};

        // Reset defaults: 12/25 gives 120 pulses in 250 edges, lock at edge 16.
        #2;
        apply_reset();
        run_count(0, 250);
        chk("dflt_ce0_count", 64'(cnt), 64'(120));
        chk("dflt_no_back_to_back", 64'(dbl), 64'(0));
        chk("dflt_lock_edge", 64'(lock_at), 64'(16));

        // Table of config writes, each followed by a counted run.
        for (int v = 0; v < 7; v++) begin
            write(vecs[v].ch, vecs[v].inc, vecs[v].mod);
            chk($sformatf("vec%0d_ce_after_write", v), 64'(ce[vecs[v].ch]), 64'(0));
            chk($sformatf("vec%0d_locked_after_write", v), 64'(locked), 64'(0));
            run_count(vecs[v].ch, vecs[v].n);
            chk($sformatf("vec%0d_ce_count", v), 64'(cnt), 64'(vecs[v].exp_ce));
            chk($sformatf("vec%0d_lock_at", v), 64'(lock_at), 64'(vecs[v].exp_lock_at));
            chk($sformatf("vec%0d_cfg_err", v), 64'(cfg_err), 64'(vecs[v].exp_err));
        end

        // Write on the crossing edge: no ce then, next ce three edges later.
        write(0, 12, 25);
        tick();
        tick();
        write(0, 12, 25);
        chk("cross_write_no_ce", 64'(ce[0]), 64'(0));
        seq = '0;
        for (int t = 0; t < 3; t++) begin
            tick();
            seq = {seq[1:0], ce[0]};
        end
        chk("cross_first_ce_seq", 64'(seq), 64'(3'b001));

        // Mid-run reset after runtime config: immediate clear, rate reverts to 12/25.
        write(0, 1, 2);
        for (int t = 0; t < 10; t++) tick();
        #2;
        apply_reset();
        run_count(0, 250);
        chk("rst_revert_ce0_count", 64'(cnt), 64'(120));
        chk("rst_revert_lock_edge", 64'(lock_at), 64'(16));

        // Out-of-range channel: nothing changes, even for invalid values.
        write(3, 7, 3);
        chk("oor_cfg_err", 64'(cfg_err), 64'(0));
        chk("oor_locked", 64'(locked), 64'(1));
        for (int t = 0; t < 5; t++) tick();
        chk("oor_locked_later", 64'(locked), 64'(1));

        // Randomized writes (including invalid and out-of-range) against the model.
        for (int t = 0; t < 3000; t++) begin
            if ($urandom_range(0, 15) == 0) begin
                r_ch  = int'($urandom_range(0, 3));
                r_mod = int'($urandom_range(0, 12));
                r_inc = int'($urandom_range(0, 14));
                write(r_ch, r_inc, r_mod);
            end else begin
                tick();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
